// File: rtl/cache_pkg.sv
// Shared types and defaults for the tag-array line refresh controller.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } refresh_state_e;

    localparam int DEFAULT_NUM_SETS = 64;
    localparam int DEFAULT_NUM_WAYS = 4;
    localparam int DEFAULT_TAG_BITS = 22;
    localparam int REFRESHED_CNT_W  = 16;

    // Index width that never collapses to zero bits.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Free-running interval counter; tick marks the last cycle of each interval.
module refresh_timer
    import cache_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W    = width_min1(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/line_refresh_ctrl.sv
// Periodic tag-array sweep: reads and rewrites every valid line, sharing the
// single array port with the CPU under a starvation-bounded arbitration.
module line_refresh_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_SETS         = DEFAULT_NUM_SETS,
    parameter int NUM_WAYS         = DEFAULT_NUM_WAYS,
    parameter int TAG_BITS         = DEFAULT_TAG_BITS,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int STARVE_LIMIT     = 16,
    parameter int INDEX_BITS       = $clog2(NUM_SETS),
    parameter int WAY_BITS         = width_min1(NUM_WAYS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [INDEX_BITS-1:0]      cpu_index,
    input  logic [WAY_BITS-1:0]        cpu_way,
    input  logic [TAG_BITS-1:0]        cpu_wdata,
    output logic                       cpu_gnt,
    output logic [INDEX_BITS-1:0]      ref_set,
    input  logic [NUM_WAYS-1:0]        ref_valid,
    input  logic [TAG_BITS-1:0]        arr_rdata,
    output logic                       arr_we,
    output logic [INDEX_BITS-1:0]      arr_index,
    output logic [WAY_BITS-1:0]        arr_way,
    output logic [TAG_BITS-1:0]        arr_wdata,
    output logic                       ref_busy,
    output logic                       sweep_done,
    output logic                       overrun,
    output logic [REFRESHED_CNT_W-1:0] refreshed_cnt
);

    localparam int                    STARVE_W = width_min1(STARVE_LIMIT + 1);
    localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(NUM_SETS - 1);
    localparam logic [WAY_BITS-1:0]   LAST_WAY = WAY_BITS'(NUM_WAYS - 1);

    refresh_state_e             state, state_nxt;
    logic [INDEX_BITS-1:0]      set_ptr, set_nxt, adv_set;
    logic [WAY_BITS-1:0]        way_ptr, way_nxt, adv_way;
    logic [STARVE_W-1:0]        starve_cnt, starve_nxt;
    logic [TAG_BITS-1:0]        tag_q, tag_nxt;
    logic [REFRESHED_CNT_W-1:0] refreshed_nxt;
    logic                       sweep_done_nxt, overrun_nxt;
    logic                       tick, urgent, rd_grant, refresh_owns, last_line;

    refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign urgent       = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
    assign rd_grant     = (state == ST_RD) && (!cpu_req || urgent);
    assign refresh_owns = rd_grant || (state == ST_WR);
    assign last_line    = (set_ptr == LAST_SET) && (way_ptr == LAST_WAY);
    assign ref_set      = set_ptr;

    // Way-major walk; the pointer wraps to (0,0) after the last line.
    always_comb begin
        adv_set = set_ptr;
        adv_way = way_ptr + 1'b1;
        if (way_ptr == LAST_WAY) begin
            adv_way = '0;
            adv_set = last_line ? '0 : set_ptr + 1'b1;
        end
    end

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        set_nxt        = set_ptr;
        way_nxt        = way_ptr;
        starve_nxt     = starve_cnt;
        tag_nxt        = tag_q;
        refreshed_nxt  = refreshed_cnt;
        sweep_done_nxt = 1'b0;
        overrun_nxt    = overrun || (tick && (state != ST_IDLE));

        case (state)
            ST_IDLE: if (tick) begin
                state_nxt = ST_SCAN;
                set_nxt   = '0;
                way_nxt   = '0;
            end
            ST_SCAN: begin
                if (ref_valid[way_ptr]) begin
                    state_nxt = ST_RD;
                end else begin
                    set_nxt = adv_set;
                    way_nxt = adv_way;
                    if (last_line) begin
                        state_nxt      = ST_IDLE;
                        sweep_done_nxt = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (rd_grant) begin
                    tag_nxt    = arr_rdata;
                    starve_nxt = '0;
                    state_nxt  = ST_WR;
                end else begin
                    starve_nxt = starve_cnt + 1'b1;
                end
            end
            ST_WR: begin
                if (refreshed_cnt != '1) refreshed_nxt = refreshed_cnt + 1'b1;
                set_nxt = adv_set;
                way_nxt = adv_way;
                if (last_line) begin
                    state_nxt      = ST_IDLE;
                    sweep_done_nxt = 1'b1;
                end else begin
                    state_nxt = ST_SCAN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            set_ptr       <= '0;
            way_ptr       <= '0;
            starve_cnt    <= '0;
            tag_q         <= '0;
            refreshed_cnt <= '0;
            sweep_done    <= 1'b0;
            overrun       <= 1'b0;
            ref_busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            set_ptr       <= set_nxt;
            way_ptr       <= way_nxt;
            starve_cnt    <= starve_nxt;
            tag_q         <= tag_nxt;
            refreshed_cnt <= refreshed_nxt;
            sweep_done    <= sweep_done_nxt;
            overrun       <= overrun_nxt;
            ref_busy      <= (state_nxt != ST_IDLE);
        end
    end

    // Port mux is combinational so a granted RD and its WR need only two owned cycles.
    always_comb begin
        cpu_gnt   = cpu_req && !refresh_owns;
        arr_we    = 1'b0;
        arr_index = set_ptr;
        arr_way   = way_ptr;
        arr_wdata = tag_q;
        if (cpu_gnt) begin
            arr_we    = cpu_we;
            arr_index = cpu_index;
            arr_way   = cpu_way;
            arr_wdata = cpu_wdata;
        end else if (state == ST_WR) begin
            arr_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_line_refresh_ctrl.sv
// Directed bench: 4 sets x 2 ways, interval 32 (main) and interval 8 (overrun case).
module tb_line_refresh_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cpu_req, cpu_we;
    logic [1:0] cpu_index;
    logic [0:0] cpu_way;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic [1:0] ref_set;
    logic [1:0] ref_valid;
    logic [7:0] arr_rdata;
    logic       arr_we;
    logic [1:0] arr_index;
    logic [0:0] arr_way;
    logic [7:0] arr_wdata;
    logic       ref_busy, sweep_done, overrun;
    logic [15:0] refreshed_cnt;

    logic       ov_cpu_gnt, ov_arr_we, ov_busy, ov_sweep_done, ov_overrun;
    logic [1:0] ov_ref_set, ov_arr_index;
    logic [0:0] ov_arr_way;
    logic [7:0] ov_arr_wdata;
    logic [15:0] ov_refreshed;

    line_refresh_ctrl #(
        .NUM_SETS(4), .NUM_WAYS(2), .TAG_BITS(8), .REFRESH_INTERVAL(32), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_index(cpu_index), .cpu_way(cpu_way), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .ref_set(ref_set), .ref_valid(ref_valid), .arr_rdata(arr_rdata), .arr_we(arr_we),
        .arr_index(arr_index), .arr_way(arr_way), .arr_wdata(arr_wdata), .ref_busy(ref_busy),
        .sweep_done(sweep_done), .overrun(overrun), .refreshed_cnt(refreshed_cnt)
    );

    line_refresh_ctrl #(
        .NUM_SETS(4), .NUM_WAYS(2), .TAG_BITS(8), .REFRESH_INTERVAL(8), .STARVE_LIMIT(4)
    ) dut_ov (
        .clk(clk), .rst_n(rst_n), .cpu_req(1'b1), .cpu_we(1'b0),
        .cpu_index(2'd0), .cpu_way(1'b0), .cpu_wdata(8'h00), .cpu_gnt(ov_cpu_gnt),
        .ref_set(ov_ref_set), .ref_valid(2'b11), .arr_rdata(8'hC3), .arr_we(ov_arr_we),
        .arr_index(ov_arr_index), .arr_way(ov_arr_way), .arr_wdata(ov_arr_wdata), .ref_busy(ov_busy),
        .sweep_done(ov_sweep_done), .overrun(ov_overrun), .refreshed_cnt(ov_refreshed)
    );

    // Tag-array model: reset loads tag = {set, way} except a marker at (2,1).
    logic [7:0] mem [0:3][0:1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 2; w++)
                    mem[s][w] <= 8'((s << 4) | w);
            mem[2][1] <= 8'h5A;
        end else if (arr_we) begin
            mem[arr_index][arr_way] <= arr_wdata;
        end
    end
    assign arr_rdata = mem[arr_index][arr_way];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int writes, way1_writes, bad_wdata, dones, done_cyc, busy_cnt, blocked;
    int ov_dones = 0, ov_done_cyc = -1;
    logic [7:0] wr_2_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        writes = 0; way1_writes = 0; bad_wdata = 0; dones = 0;
        done_cyc = -1; busy_cnt = 0; blocked = 0; wr_2_1 = 8'h00;
    endtask

    // One clock; samples land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (arr_we && !cpu_gnt) begin
            writes++;
            if (arr_way != 1'b0) way1_writes++;
            if (arr_index == 2'd2 && arr_way == 1'b1) wr_2_1 = arr_wdata;
            if (arr_wdata !== mem[arr_index][arr_way]) bad_wdata++;
        end
        if (sweep_done) begin dones++; done_cyc = cyc; end
        if (ref_busy) busy_cnt++;
        if (cpu_req && !cpu_gnt) blocked++;
        if (ov_sweep_done) begin ov_dones++; ov_done_cyc = cyc; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_index = 2'd0; cpu_way = 1'b0; cpu_wdata = 8'h00; ref_valid = 2'b11;
        clr();
        run(2);
        cyc = 0;
        chk("rst_busy", ref_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_cnt", refreshed_cnt, 0);
        chk("rst_ref_set", ref_set, 0);
        chk("rst_arr_we", arr_we, 0);
        chk("rst_ov_overrun", ov_overrun, 0);
        rst_n = 1'b1;

        // Full sweep, all valid, no CPU traffic.
        run(31);
        chk("idle_before_tick", ref_busy, 0);
        chk("ov_busy_c31", ov_busy, 1);
        chk("ov_overrun_c31", ov_overrun, 1);
        step();
        chk("sweep_start_c32", ref_busy, 1);
        chk("scan_no_write", arr_we, 0);
        clr();
        run(30);
        chk("t1_writes", writes, 8);
        chk("t1_wdata_ok", bad_wdata, 0);
        chk("t1_tag_2_1", wr_2_1, 8'h5A);
        chk("t1_dones", dones, 1);
        chk("t1_done_cyc", done_cyc, 56);
        chk("t1_busy_cycles", busy_cnt, 23);
        chk("t1_cnt", refreshed_cnt, 8);
        chk("t1_overrun", overrun, 0);
        chk("ov_no_done_yet", ov_dones, 0);
        chk("ov_cnt_c62", ov_refreshed, 7);

        // Only way 0 valid.
        ref_valid = 2'b01;
        clr();
        run(33);
        chk("t2_writes", writes, 4);
        chk("t2_way1_writes", way1_writes, 0);
        chk("t2_done_cyc", done_cyc, 80);
        chk("t2_busy_cycles", busy_cnt, 16);
        chk("t2_cnt", refreshed_cnt, 12);
        chk("ov_dones_once", ov_dones, 1);
        chk("ov_done_cyc", ov_done_cyc, 64);
        chk("ov_overrun_sticky", ov_overrun, 1);

        // CPU requests every cycle: RD denied 4 times, then preempts.
        ref_valid = 2'b11;
        cpu_req = 1'b1;
        run(5);
        chk("t3_denied_c100", cpu_gnt, 1);
        step();
        chk("t3_preempt_c101", cpu_gnt, 0);
        chk("t3_rd_no_we", arr_we, 0);
        step();
        chk("t3_wr_gnt_c102", cpu_gnt, 0);
        chk("t3_wr_we_c102", arr_we, 1);
        step();
        chk("t3_scan_gnt_c103", cpu_gnt, 1);
        clr();
        run(56);
        chk("t3_blocked", blocked, 14);
        chk("t3_writes", writes, 7);
        chk("t3_wdata_ok", bad_wdata, 0);
        chk("t3_done_cyc", done_cyc, 152);
        chk("t3_cnt", refreshed_cnt, 20);
        chk("t3_overrun", overrun, 1);

        // CPU writes 0x33 to (1,0) while refresh scans that line.
        cpu_req = 1'b0;
        run(7);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_index = 2'd1; cpu_way = 1'b0; cpu_wdata = 8'h33;
        #1;
        chk("t4_scan_set", ref_set, 1);
        chk("t4_cpu_gnt", cpu_gnt, 1);
        chk("t4_cpu_we", arr_we, 1);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk("t4_rd_we", arr_we, 0);
        chk("t4_rd_gnt", cpu_gnt, 0);
        step();
        chk("t4_wr_we", arr_we, 1);
        chk("t4_wr_data", arr_wdata, 8'h33);
        chk("t4_wr_index", arr_index, 1);
        chk("t4_wr_way", arr_way, 0);
        clr();
        run(23);
        chk("t4_done_cyc", done_cyc, 184);
        chk("t4_writes", writes, 5);
        chk("t4_cnt", refreshed_cnt, 28);

        // Reset while an RD is pending.
        cpu_req = 1'b1;
        run(2);
        chk("t5_in_sweep", ref_busy, 1);
        chk("t5_rd_denied", cpu_gnt, 1);
        rst_n = 1'b0;
        step();
        chk("t5_busy", ref_busy, 0);
        chk("t5_arr_we", arr_we, 0);
        chk("t5_cnt", refreshed_cnt, 0);
        chk("t5_overrun", overrun, 0);
        rst_n = 1'b1;
        clr();
        run(31);
        chk("t5_quiet_busy", busy_cnt, 0);
        chk("t5_quiet_writes", writes, 0);
        step();
        chk("t5_restart", ref_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
